keypad_code_buffer: RTL and testbench

- Parametrised successor of the keypad digit register.
- Takes key events from the keypad scanner (`found` level plus 4-bit `num`) and packs accepted digits into an N-digit shift register.
- Adds backspace, enter/lock, synchronous clear, occupancy count, full/reject flags and a last-digit output that feeds the 7-segment decoder.
- Sits between the keypad scanner and the display decoder / code-comparison logic.

---
 rtl/keypad_code_buffer.sv | 132 +++++++++++++
 tb/tb_keypad_code_buffer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/keypad_code_buffer.sv
// keypad_code_buffer: packs keypad digits into an N-digit shift register with
// backspace, enter/lock, synchronous clear, occupancy count and full/reject flags.
// Optional build macro KEYPAD_SYNC_IN_EN inserts a 2-flop synchroniser on found/num.
module keypad_code_buffer #(
  parameter int         NUM_DIGITS = 10,
  parameter logic [3:0] KEY_BS     = 4'hA,
  parameter logic [3:0] KEY_ENT    = 4'hB,
  parameter int         CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    found,
  input  logic [3:0]              num,
  input  logic                    clear,
  output logic [NUM_DIGITS*4-1:0] registro,
  output logic [CNT_W-1:0]        count,
  output logic [3:0]              disp,
  output logic                    full,
  output logic                    locked,
  output logic                    entered,
  output logic                    reject
);

  localparam int RW = NUM_DIGITS * 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_DIGITS);

  typedef enum logic [1:0] {ENTRY, HELD, LOCKED} state_t;

  state_t     state;
  logic       key_found;
  logic [3:0] key_num;

`ifdef KEYPAD_SYNC_IN_EN
  logic       found_s1, found_s2;
  logic [3:0] num_s1, num_s2;

  // Two-stage synchroniser; num travels with found so the code stays aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      found_s1 <= 1'b0;
      found_s2 <= 1'b0;
      num_s1   <= '0;
      num_s2   <= '0;
    end else begin
      found_s1 <= found;
      num_s1   <= num;
      found_s2 <= found_s1;
      num_s2   <= num_s1;
    end
  end

  assign key_found = found_s2;
  assign key_num   = num_s2;
`else
  assign key_found = found;
  assign key_num   = num;
`endif

  // Press-handling FSM; every output is a register updated alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ENTRY;
      registro <= '0;
      count    <= '0;
      disp     <= '0;
      full     <= 1'b0;
      locked   <= 1'b0;
      entered  <= 1'b0;
      reject   <= 1'b0;
    end else begin
      entered <= 1'b0;
      reject  <= 1'b0;
      if (clear) begin
        // clear overrides any key sampled on the same edge; a held key is
        // parked in HELD so it is not taken as a fresh press
        registro <= '0;
        count    <= '0;
        disp     <= '0;
        full     <= 1'b0;
        locked   <= 1'b0;
        state    <= key_found ? HELD : ENTRY;
      end else begin
        unique case (state)
          ENTRY: begin
            if (key_found) begin
              state <= HELD;
              if (key_num == KEY_BS) begin
                if (count != '0) begin
                  registro <= {4'h0, registro[RW-1:4]};
                  disp     <= registro[7:4];
                  count    <= count - 1'b1;
                  full     <= 1'b0;
                end else begin
                  reject <= 1'b1;
                end
              end else if (key_num == KEY_ENT) begin
                if (count != '0) begin
                  state   <= LOCKED;
                  locked  <= 1'b1;
                  entered <= 1'b1;
                end else begin
                  reject <= 1'b1;
                end
              end else if (key_num <= 4'd9) begin
                if (count != CNT_MAX) begin
                  registro <= {registro[RW-5:0], key_num};
                  disp     <= key_num;
                  count    <= count + 1'b1;
                  full     <= (count == CNT_MAX - 1'b1);
                end else begin
                  reject <= 1'b1;
                end
              end else begin
                reject <= 1'b1;
              end
            end
          end
          HELD: begin
            if (!key_found) state <= ENTRY;
          end
          LOCKED: begin
            locked <= 1'b1;
          end
          default: begin
            state <= ENTRY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_code_buffer.sv
// Testbench for keypad_code_buffer: directed key sequences push expected output
// snapshots (tagged with the clock edge they belong to) into a queue; a monitor
// pops and compares them half a cycle after the matching edge.
module tb_keypad_code_buffer;

`ifdef KEYPAD_SYNC_IN_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        found;
  logic [3:0]  num;
  logic        clear;
  logic [39:0] registro;
  logic [3:0]  count;
  logic [3:0]  disp;
  logic        full, locked, entered, reject;

  keypad_code_buffer #(.NUM_DIGITS(10), .KEY_BS(4'hA), .KEY_ENT(4'hB)) dut (
    .clk(clk), .rst(rst), .found(found), .num(num), .clear(clear),
    .registro(registro), .count(count), .disp(disp), .full(full),
    .locked(locked), .entered(entered), .reject(reject)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       nm;
    logic [39:0] r;
    int          cnt;
    logic [3:0]  d;
    bit          fl, lk, en, rj;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push(input string nm, input int dly, input logic [39:0] r,
                      input int cnt, input bit fl, input bit lk, input bit en, input bit rj);
    exp_t e;
    e.cyc = cyc + dly; e.nm = nm; e.r = r; e.cnt = cnt; e.d = r[3:0];
    e.fl = fl; e.lk = lk; e.en = en; e.rj = rj;
    q.push_back(e);
  endtask

  // Monitor: compares each expectation against the DUT after its edge
  always @(negedge clk) begin
    #1;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (e.cyc < cyc) begin
        fails++;
        $display("FAIL %s: check missed (cycle %0d, now %0d)", e.nm, e.cyc, cyc);
      end else if (registro !== e.r || int'(count) != e.cnt || disp !== e.d ||
                   full !== e.fl || locked !== e.lk || entered !== e.en || reject !== e.rj) begin
        fails++;
        $display("FAIL %s @%0d: got reg=%h cnt=%0d disp=%h full=%b lock=%b ent=%b rej=%b, want reg=%h cnt=%0d disp=%h full=%b lock=%b ent=%b rej=%b",
                 e.nm, cyc, registro, count, disp, full, locked, entered, reject,
                 e.r, e.cnt, e.d, e.fl, e.lk, e.en, e.rj);
      end
    end
  end

  // One press: held 5 cycles then 3 idle; checks on action edge, the cycle after
  // (pulse gone) and near the end of the hold (no second action)
  task automatic key(input logic [3:0] k, input string nm, input logic [39:0] r,
                     input int cnt, input bit fl, input bit lk, input bit en, input bit rj);
    @(negedge clk);
    push(nm, LAT, r, cnt, fl, lk, en, rj);
    push({nm, "_next"}, LAT + 1, r, cnt, fl, lk, 1'b0, 1'b0);
    push({nm, "_hold"}, LAT + 4, r, cnt, fl, lk, 1'b0, 1'b0);
    found = 1'b1; num = k;
    repeat (5) @(negedge clk);
    found = 1'b0; num = 4'h0;
    repeat (3) @(negedge clk);
  endtask

  // Clear, optionally coinciding with a press that must be swallowed
  task automatic clr(input bit with_key, input logic [3:0] k, input string nm);
    @(negedge clk);
    push(nm, 1, '0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    clear = 1'b1;
    if (with_key) begin
      push({nm, "_sync"}, LAT + 1, '0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      push({nm, "_held"}, 5, '0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      found = 1'b1; num = k;
      repeat (LAT) @(negedge clk);
      clear = 1'b0;
      repeat (5 - LAT) @(negedge clk);
      found = 1'b0; num = 4'h0;
    end else begin
      @(negedge clk);
      clear = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [39:0] re;
    rst = 1'b1; found = 1'b0; num = 4'h0; clear = 1'b0;
    @(negedge clk);
    push("reset", 0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;

    key(4'd1, "d1", 40'h1, 1, 0, 0, 0, 0);
    key(4'd2, "d2", 40'h12, 2, 0, 0, 0, 0);
    key(4'd3, "d3", 40'h123, 3, 0, 0, 0, 0);

    clr(1'b0, 4'h0, "clr_a");
    key(4'd4, "d4", 40'h4, 1, 0, 0, 0, 0);
    key(4'd5, "d5", 40'h45, 2, 0, 0, 0, 0);
    key(4'hA, "bs1", 40'h4, 1, 0, 0, 0, 0);
    key(4'hA, "bs2", 40'h0, 0, 0, 0, 0, 0);
    key(4'hA, "bs_empty", 40'h0, 0, 0, 0, 0, 1);

    re = '0;
    for (int d = 0; d < 10; d++) begin
      logic [3:0] dg;
      dg = 4'(d);
      re = {re[35:0], dg};
      key(dg, $sformatf("fill%0d", d), re, d + 1, d == 9, 0, 0, 0);
    end
    key(4'd7, "over_full", 40'h0123456789, 10, 1, 0, 0, 1);
    key(4'hC, "bad_code", 40'h0123456789, 10, 1, 0, 0, 1);

    clr(1'b0, 4'h0, "clr_b");
    key(4'd9, "d9", 40'h9, 1, 0, 0, 0, 0);
    key(4'd8, "d8", 40'h98, 2, 0, 0, 0, 0);
    key(4'hB, "enter", 40'h98, 2, 0, 1, 1, 0);
    key(4'd5, "locked_key", 40'h98, 2, 0, 1, 0, 0);
    clr(1'b0, 4'h0, "clr_locked");

    key(4'hB, "enter_empty", 40'h0, 0, 0, 0, 0, 1);
    clr(1'b1, 4'd6, "clr_with_key");

    key(4'd1, "r1", 40'h1, 1, 0, 0, 0, 0);
    key(4'd2, "r2", 40'h12, 2, 0, 0, 0, 0);
    key(4'd3, "r3", 40'h123, 3, 0, 0, 0, 0);
    key(4'd4, "r4", 40'h1234, 4, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    push("async_rst", 0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #3 rst = 1'b0;
    key(4'd2, "post_rst", 40'h2, 1, 0, 0, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #2;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: never checked", e.nm);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
